// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, alu_op encodings, ctrl bit positions and field offsets.
package decode_pkg;

    localparam int OPC_LSB = 21;
    localparam int OPC_W   = 11;
    localparam int RM_LSB  = 16;
    localparam int RN_LSB  = 5;
    localparam int RD_LSB  = 0;

    localparam int D_IMM_LSB  = 12;
    localparam int D_IMM_W    = 9;
    localparam int CB_IMM_LSB = 5;
    localparam int CB_IMM_W   = 19;
    localparam int B_IMM_LSB  = 0;
    localparam int B_IMM_W    = 26;

    localparam logic [10:0] OPC_LDUR    = 11'b11111000010;
    localparam logic [10:0] OPC_STUR    = 11'b11111000000;
    localparam logic [10:0] OPC_ADD     = 11'b10001011000;
    localparam logic [10:0] OPC_SUB     = 11'b11001011000;
    localparam logic [10:0] OPC_AND     = 11'b10001010000;
    localparam logic [10:0] OPC_ORR     = 11'b10101010000;
    localparam logic [7:0]  OPC_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OPC_B_PFX   = 6'b000101;

    localparam logic [1:0] ALU_OP_LDST  = 2'b00;
    localparam logic [1:0] ALU_OP_CBZ   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    // ex_ctrl = {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
    localparam int CTRL_W          = 10;
    localparam int CTRL_REG2_LOC   = 9;
    localparam int CTRL_UNCOND     = 8;
    localparam int CTRL_BRANCH     = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_OP_LSB = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_ALU_SRC    = 1;
    localparam int CTRL_REG_WRITE  = 0;

    typedef enum logic [2:0] {
        IC_NOP,
        IC_LDUR,
        IC_STUR,
        IC_RTYPE,
        IC_CBZ,
        IC_B
    } instr_class_e;

    function automatic instr_class_e classify(input logic [10:0] opc);
        if (opc == OPC_LDUR)
            return IC_LDUR;
        else if (opc == OPC_STUR)
            return IC_STUR;
        else if (opc == OPC_ADD || opc == OPC_SUB || opc == OPC_AND || opc == OPC_ORR)
            return IC_RTYPE;
        else if (opc[10:3] == OPC_CBZ_PFX)
            return IC_CBZ;
        else if (opc[10:5] == OPC_B_PFX)
            return IC_B;
        else
            return IC_NOP;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Two-read/one-write register file; top index is XZR (reads zero, ignores writes), with write-through bypass.
module decode_regfile
    import decode_pkg::*;
#(
    parameter int WORD     = 64,
    parameter int NUM_REGS = 32,
    localparam int RA      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA-1:0]   rd_addr1_i,
    output logic [WORD-1:0] rd_data1_o,
    input  logic [RA-1:0]   rd_addr2_i,
    output logic [WORD-1:0] rd_data2_o,
    input  logic            wr_en_i,
    input  logic [RA-1:0]   wr_addr_i,
    input  logic [WORD-1:0] wr_data_i
);

    localparam logic [RA-1:0] XZR = RA'(NUM_REGS - 1);

    logic [WORD-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i && wr_addr_i != XZR) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data1_o = (rd_addr1_i == XZR)                      ? '0        :
                        (wr_en_i && wr_addr_i == rd_addr1_i)     ? wr_data_i :
                                                                   regs_q[rd_addr1_i];
    assign rd_data2_o = (rd_addr2_i == XZR)                      ? '0        :
                        (wr_en_i && wr_addr_i == rd_addr2_i)     ? wr_data_i :
                                                                   regs_q[rd_addr2_i];

endmodule

// File: rtl/decode_pipe.sv
// LEGv8 decode stage with registered ID/EX boundary and valid/ready handshakes.
// Build option: DECODE_HAZARD_EN enables load-use bubble insertion.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int WORD      = 64,
    parameter int NUM_REGS  = 32,
    parameter int INSTR_LEN = 32,
    localparam int RA       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [INSTR_LEN-1:0] if_instr,
    output logic                 if_ready,
    input  logic                 wb_en,
    input  logic [RA-1:0]        wb_reg,
    input  logic [WORD-1:0]      wb_data,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [WORD-1:0]      ex_read_data1,
    output logic [WORD-1:0]      ex_read_data2,
    output logic [WORD-1:0]      ex_sign_ext,
    output logic [RA-1:0]        ex_rd,
    output logic [RA-1:0]        ex_rn,
    output logic [RA-1:0]        ex_rm,
    output logic [OPC_W-1:0]     ex_opcode,
    output logic [CTRL_W-1:0]    ex_ctrl
);

    logic [OPC_W-1:0]  opcode;
    instr_class_e      cls;
    logic [RA-1:0]     rn, rd, rm, rd2_addr;
    logic [WORD-1:0]   rd1_data, rd2_data;
    logic [WORD-1:0]   d_imm, cb_imm, b_imm;
    logic [CTRL_W-1:0] ctrl;
    logic [WORD-1:0]   sext;
    logic              adv, hazard, accept;

    logic              ex_valid_q, ex_valid_d;
    logic [WORD-1:0]   ex_rd1_q, ex_rd2_q, ex_sext_q;
    logic [RA-1:0]     ex_rd_q, ex_rn_q, ex_rm_q;
    logic [OPC_W-1:0]  ex_opc_q;
    logic [CTRL_W-1:0] ex_ctrl_q;

    assign opcode   = if_instr[OPC_LSB +: OPC_W];
    assign cls      = classify(opcode);
    assign rn       = if_instr[RN_LSB +: RA];
    assign rd       = if_instr[RD_LSB +: RA];
    assign rm       = if_instr[RM_LSB +: RA];
    assign rd2_addr = ctrl[CTRL_REG2_LOC] ? rd : rm;

    assign d_imm  = {{(WORD-D_IMM_W){if_instr[D_IMM_LSB+D_IMM_W-1]}}, if_instr[D_IMM_LSB +: D_IMM_W]};
    assign cb_imm = {{(WORD-CB_IMM_W){if_instr[CB_IMM_LSB+CB_IMM_W-1]}}, if_instr[CB_IMM_LSB +: CB_IMM_W]};
    assign b_imm  = {{(WORD-B_IMM_W){if_instr[B_IMM_LSB+B_IMM_W-1]}}, if_instr[B_IMM_LSB +: B_IMM_W]};

    decode_regfile #(
        .WORD     (WORD),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .rd_addr1_i (rn),
        .rd_data1_o (rd1_data),
        .rd_addr2_i (rd2_addr),
        .rd_data2_o (rd2_data),
        .wr_en_i    (wb_en),
        .wr_addr_i  (wb_reg),
        .wr_data_i  (wb_data)
    );

    always_comb begin
        ctrl = '0;
        sext = '0;
        case (cls)
            IC_LDUR: begin
                ctrl[CTRL_MEM_READ]             = 1'b1;
                ctrl[CTRL_MEM_TO_REG]           = 1'b1;
                ctrl[CTRL_ALU_SRC]              = 1'b1;
                ctrl[CTRL_REG_WRITE]            = 1'b1;
                ctrl[CTRL_ALU_OP_LSB +: 2]      = ALU_OP_LDST;
                sext                            = d_imm;
            end
            IC_STUR: begin
                ctrl[CTRL_REG2_LOC]             = 1'b1;
                ctrl[CTRL_MEM_WRITE]            = 1'b1;
                ctrl[CTRL_ALU_SRC]              = 1'b1;
                ctrl[CTRL_ALU_OP_LSB +: 2]      = ALU_OP_LDST;
                sext                            = d_imm;
            end
            IC_RTYPE: begin
                ctrl[CTRL_REG_WRITE]            = 1'b1;
                ctrl[CTRL_ALU_OP_LSB +: 2]      = ALU_OP_RTYPE;
            end
            IC_CBZ: begin
                ctrl[CTRL_REG2_LOC]             = 1'b1;
                ctrl[CTRL_BRANCH]               = 1'b1;
                ctrl[CTRL_ALU_OP_LSB +: 2]      = ALU_OP_CBZ;
                sext                            = cb_imm;
            end
            IC_B: begin
                ctrl[CTRL_UNCOND]               = 1'b1;
                sext                            = b_imm;
            end
            default: begin
                ctrl = '0;
                sext = '0;
            end
        endcase
    end

`ifdef DECODE_HAZARD_EN
    localparam logic [RA-1:0] XZR = RA'(NUM_REGS - 1);
    logic uses_port2;

    // rn is always compared; port 2 only matters when the instruction actually reads it
    assign uses_port2 = (cls == IC_RTYPE) || (cls == IC_STUR) || (cls == IC_CBZ);
    assign hazard     = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_rd_q != XZR) &&
                        ((ex_rd_q == rn) || (uses_port2 && (ex_rd_q == rd2_addr)));
`else
    assign hazard = 1'b0;
`endif

    assign adv        = ex_ready | ~ex_valid_q;
    assign if_ready   = adv & ~hazard;
    assign accept     = if_valid & if_ready;
    assign ex_valid_d = adv ? accept : ex_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_sext_q  <= '0;
            ex_rd_q    <= '0;
            ex_rn_q    <= '0;
            ex_rm_q    <= '0;
            ex_opc_q   <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (accept) begin
                ex_rd1_q  <= rd1_data;
                ex_rd2_q  <= rd2_data;
                ex_sext_q <= sext;
                ex_rd_q   <= rd;
                ex_rn_q   <= rn;
                ex_rm_q   <= rm;
                ex_opc_q  <= opcode;
                ex_ctrl_q <= ctrl;
            end
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_read_data1 = ex_rd1_q;
    assign ex_read_data2 = ex_rd2_q;
    assign ex_sign_ext   = ex_sext_q;
    assign ex_rd         = ex_rd_q;
    assign ex_rn         = ex_rn_q;
    assign ex_rm         = ex_rm_q;
    assign ex_opcode     = ex_opc_q;
    assign ex_ctrl       = ex_ctrl_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: spec-level model plus directed literal checks.
module tb_decode_pipe;

    localparam int WORD = 64;

`ifdef DECODE_HAZARD_EN
    localparam int HAZ = 1;
`else
    localparam int HAZ = 0;
`endif

    localparam logic [9:0] C_LDUR = 10'b0001100011;
    localparam logic [9:0] C_STUR = 10'b1000000110;
    localparam logic [9:0] C_RTYP = 10'b0000010001;
    localparam logic [9:0] C_CBZ  = 10'b1010001000;
    localparam logic [9:0] C_B    = 10'b0100000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [63:0] ex_read_data1, ex_read_data2, ex_sign_ext;
    logic [4:0]  ex_rd, ex_rn, ex_rm;
    logic [10:0] ex_opcode;
    logic [9:0]  ex_ctrl;

    int total = 0;
    int bad   = 0;

    decode_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_ready      (if_ready),
        .wb_en         (wb_en),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .ex_read_data1 (ex_read_data1),
        .ex_read_data2 (ex_read_data2),
        .ex_sign_ext   (ex_sign_ext),
        .ex_rd         (ex_rd),
        .ex_rn         (ex_rn),
        .ex_rm         (ex_rm),
        .ex_opcode     (ex_opcode),
        .ex_ctrl       (ex_ctrl)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_regs [32];
    logic        m_valid;
    logic [63:0] m_rd1, m_rd2, m_sext;
    logic [4:0]  m_rd, m_rn, m_rm;
    logic [10:0] m_opc;
    logic [9:0]  m_ctrl;

    function automatic logic [9:0] ref_ctrl(input logic [31:0] ins);
        logic [10:0] op;
        op = ins[31:21];
        if (op == 11'b11111000010) return C_LDUR;
        if (op == 11'b11111000000) return C_STUR;
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return C_RTYP;
        if (op[10:3] == 8'b10110100) return C_CBZ;
        if (op[10:5] == 6'b000101) return C_B;
        return 10'd0;
    endfunction

    function automatic logic [63:0] ref_sext(input logic [31:0] ins);
        logic [9:0] c;
        longint     v;
        c = ref_ctrl(ins);
        v = 0;
        if (c == C_LDUR || c == C_STUR) v = longint'({ins[20:12], 55'd0}) >>> 55;
        else if (c == C_CBZ)            v = longint'({ins[23:5], 45'd0}) >>> 45;
        else if (c == C_B)              v = longint'({ins[25:0], 38'd0}) >>> 38;
        return v;
    endfunction

    function automatic logic [4:0] ref_port2(input logic [31:0] ins);
        logic [9:0] c;
        c = ref_ctrl(ins);
        return c[9] ? ins[4:0] : ins[20:16];
    endfunction

    function automatic logic [63:0] ref_read(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (wb_en && wb_reg == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ins);
        logic [9:0] c;
        bit         uses2;
        c     = ref_ctrl(ins);
        uses2 = (c == C_RTYP) || (c == C_STUR) || (c == C_CBZ);
        if (HAZ == 0) return 1'b0;
        return m_valid && m_ctrl[6] && (m_rd != 5'd31) &&
               ((m_rd == ins[9:5]) || (uses2 && (m_rd == ref_port2(ins))));
    endfunction

    function automatic bit ref_if_ready();
        return (ex_ready || !m_valid) && !ref_hazard(if_instr);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_rd1 <= '0; m_rd2 <= '0; m_sext <= '0;
            m_rd <= '0; m_rn <= '0; m_rm <= '0; m_opc <= '0; m_ctrl <= '0;
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
        end else begin
            if (ex_ready || !m_valid) begin
                if (if_valid && ref_if_ready()) begin
                    m_valid <= 1'b1;
                    m_rd1   <= ref_read(if_instr[9:5]);
                    m_rd2   <= ref_read(ref_port2(if_instr));
                    m_sext  <= ref_sext(if_instr);
                    m_rd    <= if_instr[4:0];
                    m_rn    <= if_instr[9:5];
                    m_rm    <= if_instr[20:16];
                    m_opc   <= if_instr[31:21];
                    m_ctrl  <= ref_ctrl(if_instr);
                end else begin
                    m_valid <= 1'b0;
                end
            end
            if (wb_en && wb_reg != 5'd31) m_regs[wb_reg] <= wb_data;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_if_ready", 64'(if_ready), 64'(ref_if_ready()));
            check("cmp_ex_valid", 64'(ex_valid), 64'(m_valid));
            if (m_valid) begin
                check("cmp_rd1",    ex_read_data1, m_rd1);
                check("cmp_rd2",    ex_read_data2, m_rd2);
                check("cmp_sext",   ex_sign_ext,   m_sext);
                check("cmp_rd",     64'(ex_rd),    64'(m_rd));
                check("cmp_rn",     64'(ex_rn),    64'(m_rn));
                check("cmp_rm",     64'(ex_rm),    64'(m_rm));
                check("cmp_opcode", 64'(ex_opcode), 64'(m_opc));
                check("cmp_ctrl",   64'(ex_ctrl),  64'(m_ctrl));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] r_ins(input logic [10:0] op, input int rm, input int rn, input int rd);
        return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction

    function automatic logic [31:0] d_ins(input logic [10:0] op, input int imm, input int rn, input int rt);
        return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
    endfunction

    function automatic logic [31:0] cb_ins(input int imm, input int rt);
        return {8'b10110100, 19'(imm), 5'(rt)};
    endfunction

    function automatic logic [31:0] b_ins(input int imm);
        return {6'b000101, 26'(imm)};
    endfunction

    task automatic wb_write(input logic [4:0] r, input logic [63:0] d);
        wb_en = 1'b1; wb_reg = r; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input bit at_negedge, output int stalls);
        bit done;
        done     = 1'b0;
        stalls   = 0;
        if_valid = 1'b1;
        if_instr = ins;
        for (int k = 0; k < 16 && !done; k++) begin
            if (k > 0 || !at_negedge) @(negedge clk);
            if (if_ready) done = 1'b1;
            else stalls++;
        end
        if (!done) check("issue_accept", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        reset = 1'b1; if_valid = 1'b0; if_instr = '0; wb_en = 1'b0;
        wb_reg = '0; wb_data = '0; ex_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_rd1",      ex_read_data1, 64'd0);
        check("rst_rd2",      ex_read_data2, 64'd0);
        check("rst_sext",     ex_sign_ext,   64'd0);
        check("rst_fields",   64'({ex_rd, ex_rn, ex_rm, ex_opcode, ex_ctrl}), 64'd0);
        check("rst_if_ready", 64'(if_ready), 64'd1);
        @(posedge clk); #1;

        wb_write(5'd1, 64'd5);
        wb_write(5'd2, 64'd7);

        issue(r_ins(OP_ADD, 2, 1, 3), 1'b0, st);
        @(negedge clk);
        check("add_valid",  64'(ex_valid), 64'd1);
        check("add_rd1",    ex_read_data1, 64'd5);
        check("add_rd2",    ex_read_data2, 64'd7);
        check("add_aluop",  64'(ex_ctrl[4:3]), 64'd2);
        check("add_regw",   64'(ex_ctrl[0]), 64'd1);
        check("add_rd",     64'(ex_rd), 64'd3);
        check("model_add_rd1", m_rd1, 64'd5);
        @(posedge clk); #1;

        // load-use: LDUR X4 then ADD X5,X4,X1
        issue(d_ins(OP_LDUR, -8, 1, 4), 1'b0, st);
        if_valid = 1'b1;
        if_instr = r_ins(OP_ADD, 1, 4, 5);
        @(negedge clk);
        check("ldur_sext",   ex_sign_ext, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_memrd",  64'(ex_ctrl[6]), 64'd1);
        check("ldur_alusrc", 64'(ex_ctrl[1]), 64'd1);
        check("ldur_m2r",    64'(ex_ctrl[5]), 64'd1);
        check("model_ldur_sext", m_sext, 64'hFFFF_FFFF_FFFF_FFF8);
        check("loaduse_if_ready", 64'(if_ready), HAZ ? 64'd0 : 64'd1);
        issue(r_ins(OP_ADD, 1, 4, 5), 1'b1, st);
        check("loaduse_stalls", 64'(st), 64'(HAZ));
        @(negedge clk);
        check("loaduse_add_rd", 64'(ex_rd), 64'd5);
        @(posedge clk); #1;

        // downstream stall for 4 cycles
        issue(r_ins(OP_SUB, 1, 2, 6), 1'b0, st);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = r_ins(OP_ORR, 2, 1, 7);
        repeat (4) begin
            @(negedge clk);
            check("stall_if_ready", 64'(if_ready), 64'd0);
            check("stall_valid",    64'(ex_valid), 64'd1);
            check("stall_rd",       64'(ex_rd), 64'd6);
            check("stall_opcode",   64'(ex_opcode), 64'(OP_SUB));
        end
        @(posedge clk); #1;
        ex_ready = 1'b1;
        issue(r_ins(OP_ORR, 2, 1, 7), 1'b0, st);
        check("release_stalls", 64'(st), 64'd0);
        @(negedge clk);
        check("release_rd",  64'(ex_rd), 64'd7);
        check("release_opc", 64'(ex_opcode), 64'(OP_ORR));
        @(posedge clk); #1;

        // hazard while downstream is stalled
        issue(d_ins(OP_LDUR, 16, 2, 8), 1'b0, st);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = r_ins(OP_AND, 2, 8, 10);
        repeat (3) begin
            @(negedge clk);
            check("hzstall_if_ready", 64'(if_ready), 64'd0);
            check("hzstall_rd",       64'(ex_rd), 64'd8);
        end
        @(posedge clk); #1;
        ex_ready = 1'b1;
        issue(r_ins(OP_AND, 2, 8, 10), 1'b0, st);
        check("hzstall_stalls", 64'(st), 64'(HAZ));
        @(negedge clk);
        check("hzstall_and_rd", 64'(ex_rd), 64'd10);
        @(posedge clk); #1;

        // CBZ X9 with same-cycle write-back bypass
        wb_en = 1'b1; wb_reg = 5'd9; wb_data = 64'h1234;
        issue(cb_ins(-3, 9), 1'b0, st);
        @(negedge clk);
        check("cbz_rd2",  ex_read_data2, 64'h1234);
        check("cbz_sext", ex_sign_ext, 64'hFFFF_FFFF_FFFF_FFFD);
        check("cbz_ctrl", 64'(ex_ctrl), 64'(C_CBZ));
        check("model_cbz_rd2", m_rd2, 64'h1234);
        @(posedge clk); #1;

        // X9 now stored; XZR write attempts
        issue(r_ins(OP_ADD, 1, 9, 11), 1'b0, st);
        @(negedge clk);
        check("x9_stored", ex_read_data1, 64'h1234);
        @(posedge clk); #1;
        wb_write(5'd31, 64'hDEAD);
        wb_en = 1'b1; wb_reg = 5'd31; wb_data = 64'hBEEF;
        issue(r_ins(OP_ADD, 31, 31, 12), 1'b0, st);
        @(negedge clk);
        check("xzr_rd1", ex_read_data1, 64'd0);
        check("xzr_rd2", ex_read_data2, 64'd0);
        @(posedge clk); #1;

        // STUR uses rt on port 2; B and unknown opcode
        issue(d_ins(OP_STUR, 16, 1, 2), 1'b0, st);
        @(negedge clk);
        check("stur_rd2",  ex_read_data2, 64'd7);
        check("stur_sext", ex_sign_ext, 64'd16);
        check("stur_ctrl", 64'(ex_ctrl), 64'(C_STUR));
        @(posedge clk); #1;
        issue(b_ins(-2), 1'b0, st);
        @(negedge clk);
        check("b_sext", ex_sign_ext, 64'hFFFF_FFFF_FFFF_FFFE);
        check("b_ctrl", 64'(ex_ctrl), 64'(C_B));
        @(posedge clk); #1;
        issue(32'hFFFF_FFFF, 1'b0, st);
        @(negedge clk);
        check("nop_ctrl", 64'(ex_ctrl), 64'd0);
        check("nop_sext", ex_sign_ext, 64'd0);
        check("nop_valid", 64'(ex_valid), 64'd1);
        @(posedge clk); #1;

        // reset in the middle of a downstream stall
        issue(r_ins(OP_SUB, 2, 1, 14), 1'b0, st);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = r_ins(OP_ORR, 2, 1, 13);
        @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", 64'(ex_valid), 64'd0);
        check("midrst_rd",    64'(ex_rd), 64'd0);
        check("midrst_rd1",   ex_read_data1, 64'd0);
        check("midrst_if_ready", 64'(if_ready), 64'd1);
        @(posedge clk); #1;
        reset    = 1'b0;
        ex_ready = 1'b1;
        issue(r_ins(OP_ORR, 2, 1, 13), 1'b0, st);
        @(negedge clk);
        check("represent_rd",  64'(ex_rd), 64'd13);
        check("represent_rd1", ex_read_data1, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
